// File: rtl/dac_tx_pkg.sv
// Shared types and helpers for the signed-to-offset-binary DAC transmit path.
// Midscale and conversion helpers work on a wide word; callers truncate.
package dac_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] midscale(input int unsigned w);
        return MAX_W'(1) << (w - 1);
    endfunction

    // Offset binary is two's complement with the sign bit flipped.
    function automatic logic [MAX_W-1:0] to_offset_binary(
        input logic [MAX_W-1:0] data,
        input int unsigned      w
    );
        return data ^ midscale(w);
    endfunction

endpackage

// File: rtl/signed2unsigned_dac_tx_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and synchronous flush.
// Pointers wrap naturally; level carries the extra bit to tell full from empty.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/signed2unsigned_dac_tx.sv
// DAC transmit path: buffers signed samples, converts to offset binary and
// paces them out every DIV clocks, parking at midscale when disabled.
module signed2unsigned_dac_tx
    import dac_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV        = 4,
    parameter int PREFILL    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [DATA_W-1:0]             dac_data,
    output logic                          dac_wr,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          running
);

    localparam int LW   = $clog2(FIFO_DEPTH) + 1;
    localparam int DIVW = $clog2(DIV);
    localparam logic [DATA_W-1:0] MID = DATA_W'(midscale(DATA_W));

    state_t            state;
    state_t            state_nx;
    logic [DIVW-1:0]   div_cnt;
    logic [DIVW-1:0]   div_nx;
    logic              tick;
    logic              go_idle;
    logic              park;
    logic              push;
    logic              pop;
    logic              und_nx;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] head_ob;

    assign s_ready = (state != IDLE) && !full;
    assign running = (state == RUN);
    assign tick    = (state == RUN) && (div_cnt == DIVW'(DIV - 1));
    // A sample handed over while en falls is dropped with the flush.
    assign push    = s_valid && s_ready && !go_idle;
    assign park    = go_idle && (dac_data != MID);
    assign head_ob = DATA_W'(to_offset_binary(MAX_W'(head), DATA_W));

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (go_idle),
        .push  (push),
        .din   (s_data),
        .pop   (pop),
        .dout  (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nx = state;
        div_nx   = '0;
        go_idle  = 1'b0;
        pop      = 1'b0;
        und_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) state_nx = PRIME;
            end
            PRIME: begin
                if (!en) begin
                    state_nx = IDLE;
                    go_idle  = 1'b1;
                end else if (fifo_level >= LW'(PREFILL)) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nx = IDLE;
                    go_idle  = 1'b1;
                end else begin
                    div_nx = tick ? '0 : div_cnt + 1'b1;
                    if (tick && empty) begin
                        und_nx   = 1'b1;
                        state_nx = PRIME;
                    end else if (tick) begin
                        pop = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            dac_data <= MID;
            dac_wr   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nx;
            div_cnt  <= div_nx;
            underrun <= und_nx;
            dac_wr   <= pop || park;
            if (pop) begin
                dac_data <= head_ob;
            end else if (park) begin
                dac_data <= MID;
            end
        end
    end

endmodule

// File: tb/tb_signed2unsigned_dac_tx.sv
// Self-checking bench: queue-based reference model plus directed sequences.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_signed2unsigned_dac_tx;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int DV = 4;
    localparam int PF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready;
    logic [7:0] dac_data;
    logic       dac_wr;
    logic       underrun;
    logic [2:0] fifo_level;
    logic       running;

    signed2unsigned_dac_tx #(
        .DATA_W     (W),
        .FIFO_DEPTH (D),
        .DIV        (DV),
        .PREFILL    (PF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .dac_data   (dac_data),
        .dac_wr     (dac_wr),
        .underrun   (underrun),
        .fifo_level (fifo_level),
        .running    (running)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model state: 0 idle, 1 waiting for prefill, 2 streaming
    int         m_state = 0;
    int         m_div = 0;
    logic [7:0] q[$];
    logic [7:0] m_data = 8'h80;
    logic       m_wr = 1'b0;
    logic       m_und = 1'b0;

    logic [7:0] wr_q[$];
    int         wr_t[$];
    int         und_cnt = 0;

    function automatic logic [7:0] conv(input logic [7:0] x);
        return 8'(int'($signed(x)) + 128);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        int lvl;
        bit rdy;
        bit pu;
        bit tk;
        cyc++;
        m_wr  = 1'b0;
        m_und = 1'b0;
        if (rst) begin
            m_state = 0;
            m_div   = 0;
            q.delete();
            m_data  = 8'h80;
        end else begin
            lvl = q.size();
            rdy = (m_state != 0) && (lvl < D);
            pu  = s_valid && rdy;
            if (m_state != 0 && !en) begin
                q.delete();
                if (m_data != 8'h80) begin
                    m_data = 8'h80;
                    m_wr   = 1'b1;
                end
                m_state = 0;
                m_div   = 0;
            end else if (m_state == 0) begin
                if (en) m_state = 1;
            end else if (m_state == 1) begin
                if (pu) q.push_back(s_data);
                if (lvl >= PF) m_state = 2;
            end else begin
                tk    = (m_div == DV - 1);
                m_div = (m_div + 1) % DV;
                if (tk && lvl == 0) begin
                    m_und   = 1'b1;
                    m_state = 1;
                    m_div   = 0;
                end else if (tk) begin
                    m_data = conv(q.pop_front());
                    m_wr   = 1'b1;
                end
                if (pu) q.push_back(s_data);
            end
        end
    end

    always @(negedge clk) begin
        chk("dac_data", int'(dac_data), int'(m_data));
        chk("dac_wr", int'(dac_wr), int'(m_wr));
        chk("underrun", int'(underrun), int'(m_und));
        chk("fifo_level", int'(fifo_level), q.size());
        chk("running", int'(running), int'(m_state == 2));
        chk("s_ready", int'(s_ready), int'(m_state != 0 && q.size() < D));
        if (dac_wr) begin
            wr_q.push_back(dac_data);
            wr_t.push_back(cyc);
        end
        if (underrun) und_cnt++;
    end

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        chk("rst_dac_data", int'(dac_data), 8'h80);
        chk("rst_dac_wr", int'(dac_wr), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_running", int'(running), 0);
        rst = 1'b0;
        #1;
        wr_q.delete();
        wr_t.delete();
        und_cnt = 0;
    endtask

    task automatic push(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        s_data  = d;
        s_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        s_valid = 1'b0;
        chk("push_accepted", int'(ok), 1);
    endtask

    task automatic wait_ff();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (dac_wr && dac_data == 8'hFF) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("wait_ff", int'(ok), 1);
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl[8];
    logic [7:0] sent[$];
    bit         saw_full;
    bit         r;
    int         k;

    initial begin
        tbl[0] = '{8'h80, 8'h00};
        tbl[1] = '{8'hFF, 8'h7F};
        tbl[2] = '{8'h00, 8'h80};
        tbl[3] = '{8'h7F, 8'hFF};
        tbl[4] = '{8'h01, 8'h81};
        tbl[5] = '{8'hFE, 8'h7E};
        tbl[6] = '{8'h40, 8'hC0};
        tbl[7] = '{8'hC0, 8'h40};

        // Conversion table and steady cadence
        @(negedge clk);
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 8; i++) push(tbl[i].din);
        for (int n = 0; n < 200 && wr_q.size() < 8; n++) begin
            @(negedge clk);
            #1;
        end
        chk("t1_count", wr_q.size() >= 8 ? 8 : wr_q.size(), 8);
        for (int i = 0; i < 8 && i < wr_q.size(); i++)
            chk("t1_code", int'(wr_q[i]), int'(tbl[i].exp));
        for (int i = 1; i < 8 && i < wr_t.size(); i++)
            chk("t1_cadence", wr_t[i] - wr_t[i-1], DV);

        // Prefill gate
        do_reset();
        en = 1'b1;
        push(8'h11);
        for (int n = 0; n < 10; n++) @(negedge clk);
        #1;
        chk("t2_running", int'(running), 0);
        chk("t2_no_wr", wr_q.size(), 0);
        chk("t2_dac_mid", int'(dac_data), 8'h80);
        chk("t2_level", int'(fifo_level), 1);
        push(8'h22);
        for (int n = 0; n < 10 && !running; n++) @(negedge clk);
        chk("t2_run", int'(running), 1);
        k = 0;
        while (!dac_wr && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t2_first_wr", k, DV);
        chk("t2_first_code", int'(dac_data), int'(conv(8'h11)));

        // Backpressure with valid held high
        do_reset();
        en = 1'b1;
        sent.delete();
        saw_full = 1'b0;
        s_data  = 8'($urandom);
        s_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            r = s_ready;
            if (fifo_level == 3'd4) saw_full = 1'b1;
            @(negedge clk);
            if (r) begin
                sent.push_back(s_data);
                s_data = 8'($urandom);
            end
        end
        s_valid = 1'b0;
        for (int n = 0; n < 40; n++) @(negedge clk);
        #1;
        chk("t3_saw_full", int'(saw_full), 1);
        chk("t3_count", wr_q.size(), sent.size());
        for (int i = 0; i < sent.size() && i < wr_q.size(); i++)
            chk("t3_order", int'(wr_q[i]), int'(conv(sent[i])));

        // Underrun and restart
        do_reset();
        en = 1'b1;
        push(8'h10);
        push(8'h20);
        push(8'h30);
        for (int n = 0; n < 100 && !underrun; n++) @(negedge clk);
        chk("t4_underrun", int'(underrun), 1);
        #1;
        chk("t4_writes", wr_q.size(), 3);
        chk("t4_hold", int'(dac_data), int'(conv(8'h30)));
        chk("t4_prime", int'(running), 0);
        chk("t4_ready", int'(s_ready), 1);
        chk("t4_und_cnt", und_cnt, 1);
        push(8'h40);
        push(8'h50);
        for (int n = 0; n < 20 && !dac_wr; n++) @(negedge clk);
        chk("t4_restart", int'(dac_wr), 1);
        chk("t4_restart_code", int'(dac_data), int'(conv(8'h40)));

        // Disable while streaming
        do_reset();
        en = 1'b1;
        push(8'h7F);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        wait_ff();
        chk("t5_level", int'(fifo_level), 3);
        en = 1'b0;
        @(negedge clk);
        chk("t5_park_wr", int'(dac_wr), 1);
        chk("t5_park_mid", int'(dac_data), 8'h80);
        chk("t5_flushed", int'(fifo_level), 0);
        chk("t5_ready", int'(s_ready), 0);
        @(negedge clk);
        chk("t5_single_wr", int'(dac_wr), 0);

        // Reset while streaming
        do_reset();
        en = 1'b1;
        push(8'h7F);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        wait_ff();
        rst = 1'b1;
        @(negedge clk);
        chk("t5r_mid", int'(dac_data), 8'h80);
        chk("t5r_no_wr", int'(dac_wr), 0);
        chk("t5r_level", int'(fifo_level), 0);
        chk("t5r_running", int'(running), 0);
        chk("t5r_ready", int'(s_ready), 0);
        rst = 1'b0;

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            en      = ($urandom_range(0, 40) != 0);
            s_valid = ($urandom_range(0, 2) != 0);
            s_data  = 8'($urandom);
            rst     = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/signed2unsigned_dac_tx.md
Name: signed2unsigned_dac_tx

Overview:
Transmit-side counterpart of the ADC capture path. It accepts two's-complement samples from DSP logic over a valid/ready handshake and buffers them in a small FIFO. It converts each sample to offset-binary (MSB inverted) and presents one sample to the DAC every DIV clocks with a write strobe. Prefill, underrun handling and midscale parking keep the DAC glitch-free when the upstream stalls or is disabled.

Parameters:
DATA_W, 8, sample width (signed in, offset-binary out)
FIFO_DEPTH, 4, FIFO entries; power of 2, >= 2
DIV, 4, clk cycles per DAC update; >= 2
PREFILL, 2, FIFO level required before output starts; 1..FIFO_DEPTH

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
en  in  1  transmit enable
s_data  in  DATA_W  signed sample, two's complement
s_valid  in  1  s_data valid
s_ready  out  1  block accepts s_data this cycle
dac_data  out  DATA_W  offset-binary DAC code, registered
dac_wr  out  1  one-cycle strobe: dac_data updated
underrun  out  1  one-cycle pulse: tick occurred with empty FIFO
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
running  out  1  high while FSM in RUN

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: dac_data = midscale (1 followed by DATA_W-1 zeros, 0x80), dac_wr=0, underrun=0, fifo_level=0, running=0, FSM=IDLE, divider=0. Reset mid-operation flushes the FIFO. dac_data is midscale on the cycle after rst is sampled high; no dac_wr is issued for it.
- Conversion: out = {~in[DATA_W-1], in[DATA_W-2:0]}. Examples: -128 (0x80)->0x00, -1 (0xFF)->0x7F, 0->0x80, +127 (0x7F)->0xFF. No saturation or rounding.
- Handshake:
  - s_ready = (state != IDLE) && (fifo_level < FIFO_DEPTH). It is combinational from registered state only.
  - A push occurs when s_valid && s_ready.
  - No fall-through: a sample pushed in cycle T can be popped in T+1 at the earliest.
  - A simultaneous push and pop in one cycle is legal; the level is unchanged.
- FSM states:
  - IDLE: s_ready=0, divider held at 0. If en=1, go to PRIME next cycle.
  - PRIME: accept pushes, no output. If en=0, go to IDLE. Else if fifo_level >= PREFILL, go to RUN.
  - RUN: divider counts 0..DIV-1 and wraps; tick when divider==DIV-1. The first tick occurs DIV-1 cycles after the first RUN cycle.
    - Tick with FIFO non-empty: pop the head; dac_data = converted head and dac_wr=1, both in the cycle after the tick.
    - Tick with FIFO empty: underrun=1 in the cycle after the tick, dac_data holds its last value, no dac_wr, state -> PRIME.
    - en=0 takes priority over a tick: go to IDLE.
- Any state to IDLE caused by en=0:
  - FIFO flushed on the IDLE entry cycle.
  - If dac_data != midscale, it is written to midscale with one dac_wr pulse on entry.
  - A sample accepted in the same cycle en falls is discarded.
- Output cadence in steady state: exactly one dac_wr per DIV cycles, with no jitter.
- fifo_level wraps correctly: pointers are $clog2(FIFO_DEPTH) bits wide, and the level saturates logically at FIFO_DEPTH because the handshake prevents overflow.

Decomposition:
- Package dac_tx_pkg:
  - state enum {IDLE, PRIME, RUN}
  - function midscale(DATA_W)
  - function to_offset_binary(data)
- Sub-module sync_fifo (parameters DATA_W, DEPTH):
  - ports clk, rst, push, din, pop, dout, level, full, empty, flush
  - show-ahead dout, synchronous flush
- The top level contains the FSM, divider and output register.

Test Plan:
1. Conversion: en=1, push 0x80, 0xFF, 0x00, 0x7F, then keep the FIFO fed -> dac_data sequence 0x00, 0x7F, 0x80, 0xFF, with dac_wr exactly every 4 clocks.
2. Prefill: after reset, en=1, push one sample only -> state stays PRIME, no dac_wr, dac_data=0x80. Push a second sample -> running=1 and first dac_wr 4 cycles after RUN entry (DIV=4).
3. Backpressure: hold s_valid=1 with DIV=4 -> s_ready drops when fifo_level=4, reasserts the cycle after each pop. No sample is lost or duplicated; compare against a scoreboard.
4. Underrun: feed 3 samples then stop -> 3 dac_wr pulses, then one underrun pulse at the next tick. dac_data holds the last code, state returns to PRIME. Resuming with 2 pushes restarts output.
5. Disable/reset mid-run: drop en while dac_data=0xFF and 3 samples are queued -> one dac_wr with 0x80, fifo_level=0, s_ready=0. Repeat with rst=1 instead -> dac_data=0x80 with no dac_wr, all outputs at reset values.
